// File: rtl/splitter_arb_pkg.sv
// Shared types and helpers for the splitter arbiter slice.
// Used by rr_arbiter and splitter_arbiter.
package splitter_arb_pkg;

    localparam int unsigned DEF_PACKET_ID_WIDTH = 5;
    localparam int unsigned DEF_NODE_COUNT      = 8;

    // lowest_set() scans vectors up to this width (covers pools up to 2^8 IDs)
    localparam int unsigned LSB_MAX_BITS = 256;
    localparam int unsigned LSB_IDX_W    = 8;

    typedef logic [DEF_PACKET_ID_WIDTH-1:0]     pkt_id_t;
    typedef logic [$clog2(DEF_NODE_COUNT)-1:0]  node_idx_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } sp_state_t;

    function automatic logic [LSB_IDX_W-1:0] lowest_set(input logic [LSB_MAX_BITS-1:0] v);
        logic [LSB_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = LSB_MAX_BITS; i > 0; i--) begin
            if (v[i-1]) idx = LSB_IDX_W'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/splitter_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first request strictly above
// ptr, wrapping back to bit 0.
module rr_arbiter
    import splitter_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0]           above;
    logic [N-1:0]           pick;
    logic [LSB_IDX_W-1:0]   idx;

    always_comb begin
        // a shift of N (ptr at top) empties the mask, falling back to the wrap
        above = req & ({N{1'b1}} << (32'(ptr) + 32'd1));
        pick  = (|above) ? above : req;
        idx   = lowest_set(LSB_MAX_BITS'(pick));
        gnt   = (|req) ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/splitter_arbiter.sv
// Round-robin front end sharing one flit splitter between REQ_COUNT requesters.
// Define SPLITTER_ARB_ID_TRACK_EN for a bitmap ID pool with release tracking.
module splitter_arbiter
    import splitter_arb_pkg::*;
#(
    parameter int unsigned REQ_COUNT       = 4,
    parameter int unsigned NODE_COUNT      = 8,
    parameter int unsigned PACKET_ID_WIDTH = 5,
    parameter int unsigned PAYLOAD         = 32,
    localparam int unsigned NW  = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1,
    localparam int unsigned RPW = $clog2(REQ_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [REQ_COUNT-1:0]         req_valid,
    input  logic [REQ_COUNT*PAYLOAD-1:0] req_data,
    input  logic [REQ_COUNT*NW-1:0]      req_dest,
    output logic [REQ_COUNT-1:0]         req_grant,
    output logic [PACKET_ID_WIDTH-1:0]   req_id,
    output logic                         sp_valid,
    output logic [PAYLOAD-1:0]           sp_packet,
    output logic [NW-1:0]                sp_node_dest,
    output logic [PACKET_ID_WIDTH-1:0]   sp_packet_id,
    input  logic                         sp_ack,
    input  logic                         rel_valid,
    input  logic [PACKET_ID_WIDTH-1:0]   rel_id,
    output logic [PACKET_ID_WIDTH:0]     ids_in_use,
    output logic                         rel_err
);

    sp_state_t                  state;
    logic [RPW-1:0]             rr_ptr;
    logic [REQ_COUNT-1:0]       gnt;
    logic [LSB_IDX_W-1:0]       win_idx;
    logic [RPW-1:0]             win;
    logic [PACKET_ID_WIDTH-1:0] alloc_id;
    logic                       id_avail;
    logic                       take;

    rr_arbiter #(.N(REQ_COUNT)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign win_idx = lowest_set(LSB_MAX_BITS'(gnt));
    assign win     = win_idx[RPW-1:0];

    // capture may coincide with the acknowledge of the packet being held
    assign take = ce && ((state == ST_EMPTY) || sp_ack) && (|req_valid) && id_avail;

    assign req_grant = take ? gnt : '0;
    assign req_id    = alloc_id;
    assign sp_valid  = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            sp_packet    <= '0;
            sp_node_dest <= '0;
            sp_packet_id <= '0;
            rr_ptr       <= RPW'(REQ_COUNT - 1);
        end else if (take) begin
            state        <= ST_HOLD;
            sp_packet    <= req_data[32'(win)*PAYLOAD +: PAYLOAD];
            sp_node_dest <= req_dest[32'(win)*NW +: NW];
            sp_packet_id <= alloc_id;
            rr_ptr       <= win;
        end else if (ce && (state == ST_HOLD) && sp_ack) begin
            state <= ST_EMPTY;
        end
    end

`ifdef SPLITTER_ARB_ID_TRACK_EN
    localparam int unsigned IDS = 2 ** PACKET_ID_WIDTH;

    logic [IDS-1:0]             free_map;
    logic [LSB_IDX_W-1:0]       free_idx;
    logic                       rel_ok;
    logic                       rel_bad;

    assign free_idx = lowest_set(LSB_MAX_BITS'(free_map));
    assign alloc_id = free_idx[PACKET_ID_WIDTH-1:0];
    assign id_avail = |free_map;
    // a released ID is still marked busy this cycle, so it cannot be re-allocated yet
    assign rel_ok   = ce && rel_valid && !free_map[rel_id];
    assign rel_bad  = ce && rel_valid &&  free_map[rel_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            free_map   <= '1;
            ids_in_use <= '0;
            rel_err    <= 1'b0;
        end else begin
            if (take)   free_map[alloc_id] <= 1'b0;
            if (rel_ok) free_map[rel_id]   <= 1'b1;
            if (take && !rel_ok)      ids_in_use <= ids_in_use + 1'b1;
            else if (!take && rel_ok) ids_in_use <= ids_in_use - 1'b1;
            if (rel_bad) rel_err <= 1'b1;
        end
    end
`else
    logic [PACKET_ID_WIDTH-1:0] id_ctr;
    logic                       unused_rel;

    assign alloc_id   = id_ctr;
    assign id_avail   = 1'b1;
    assign ids_in_use = '0;
    assign rel_err    = 1'b0;
    assign unused_rel = ^{rel_valid, rel_id};

    always_ff @(posedge clk) begin
        if (rst)       id_ctr <= '0;
        else if (take) id_ctr <= id_ctr + 1'b1;
    end
`endif

endmodule

// File: tb/tb_splitter_arbiter.sv
// Directed self-checking bench for splitter_arbiter (default parameters),
// with expectations for both ID-tracking and free-running-ID builds.
module tb_splitter_arbiter;
    import splitter_arb_pkg::*;

`ifdef SPLITTER_ARB_ID_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [11:0]  req_dest;
    logic [3:0]   req_grant;
    pkt_id_t      req_id;
    logic         sp_valid;
    logic [31:0]  sp_packet;
    node_idx_t    sp_node_dest;
    pkt_id_t      sp_packet_id;
    logic         sp_ack;
    logic         rel_valid;
    pkt_id_t      rel_id;
    logic [5:0]   ids_in_use;
    logic         rel_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    splitter_arbiter #(
        .REQ_COUNT(4), .NODE_COUNT(8), .PACKET_ID_WIDTH(5), .PAYLOAD(32)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req_valid(req_valid), .req_data(req_data), .req_dest(req_dest),
        .req_grant(req_grant), .req_id(req_id),
        .sp_valid(sp_valid), .sp_packet(sp_packet), .sp_node_dest(sp_node_dest),
        .sp_packet_id(sp_packet_id), .sp_ack(sp_ack),
        .rel_valid(rel_valid), .rel_id(rel_id),
        .ids_in_use(ids_in_use), .rel_err(rel_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        rel_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; req_valid = '0; sp_ack = 1'b0;
        rel_valid = 1'b0; rel_id = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            req_dest[i*3 +: 3]   = 3'(i + 1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sp_valid", 64'(sp_valid), 64'(0));
        chk("rst_sp_packet", 64'(sp_packet), 64'(0));
        chk("rst_sp_dest", 64'(sp_node_dest), 64'(0));
        chk("rst_sp_id", 64'(sp_packet_id), 64'(0));
        chk("rst_grant", 64'(req_grant), 64'(0));
        chk("rst_in_use", 64'(ids_in_use), 64'(0));
        chk("rst_rel_err", 64'(rel_err), 64'(0));

        // single requester
        @(negedge clk);
        req_valid = 4'b0001; sp_ack = 1'b1;
        #1;
        chk("single_grant", 64'(req_grant), 64'(4'b0001));
        chk("single_id", 64'(req_id), 64'(0));
        @(posedge clk); #1;
        chk("single_sp_valid", 64'(sp_valid), 64'(1));
        chk("single_sp_id", 64'(sp_packet_id), 64'(0));
        chk("single_sp_packet", 64'(sp_packet), 64'(32'hA000_0000));
        chk("single_sp_dest", 64'(sp_node_dest), 64'(1));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("drop_grant", 64'(req_grant), 64'(0));
        @(posedge clk); #1;
        chk("drop_sp_valid", 64'(sp_valid), 64'(0));

        // all four requesting back to back
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            req_valid = 4'b1111; sp_ack = 1'b1;
            #1;
            chk("rr_grant", 64'(req_grant), 64'(4'b0001 << (k % 4)));
            chk("rr_id", 64'(req_id), 64'(k));
            @(posedge clk); #1;
            chk("rr_sp_id", 64'(sp_packet_id), 64'(k));
            chk("rr_sp_packet", 64'(sp_packet), 64'(32'hA000_0000 + 32'(k % 4)));
        end

        // back-pressure: held packet must stay put
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            sp_ack = 1'b0;
            #1;
            chk("hold_grant", 64'(req_grant), 64'(0));
            @(posedge clk); #1;
            chk("hold_sp_valid", 64'(sp_valid), 64'(1));
            chk("hold_sp_id", 64'(sp_packet_id), 64'(4));
            chk("hold_sp_packet", 64'(sp_packet), 64'(32'hA000_0000));
        end
        @(negedge clk);
        sp_ack = 1'b1;
        #1;
        chk("ack_grant", 64'(req_grant), 64'(4'b0010));
        chk("ack_id", 64'(req_id), 64'(5));
        @(posedge clk); #1;
        chk("ack_sp_id", 64'(sp_packet_id), 64'(5));
        chk("ack_sp_packet", 64'(sp_packet), 64'(32'hA000_0001));

        // clock enable low freezes everything
        @(negedge clk);
        ce = 1'b0;
        #1;
        chk("ce_grant", 64'(req_grant), 64'(0));
        @(posedge clk); #1;
        chk("ce_sp_valid", 64'(sp_valid), 64'(1));
        chk("ce_sp_id", 64'(sp_packet_id), 64'(5));
        @(negedge clk);
        ce = 1'b1;
        #1;
        chk("ce_on_grant", 64'(req_grant), 64'(4'b0100));
        chk("ce_on_id", 64'(req_id), 64'(6));
        @(posedge clk); #1;
        chk("ce_on_sp_dest", 64'(sp_node_dest), 64'(3));
        chk("ce_on_in_use", 64'(ids_in_use), TRACK ? 64'(7) : 64'(0));

        // pool exhaustion (tracking) or ID wrap (free-running)
        do_reset();
        req_valid = 4'b0001; sp_ack = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("fill_grant", 64'(req_grant), 64'(4'b0001));
            chk("fill_id", 64'(req_id), 64'(k));
            @(posedge clk);
        end
        #1;
        chk("fill_in_use", 64'(ids_in_use), TRACK ? 64'(32) : 64'(0));
        @(negedge clk);
        rel_valid = 1'b1; rel_id = 5'd2;
        #1;
        chk("full_rel_grant", 64'(req_grant), TRACK ? 64'(0) : 64'(4'b0001));
        chk("full_rel_id", 64'(req_id), 64'(TRACK ? 0 : 0));
        @(posedge clk); #1;
        chk("full_rel_in_use", 64'(ids_in_use), TRACK ? 64'(31) : 64'(0));
        chk("full_rel_err", 64'(rel_err), 64'(0));
        @(negedge clk);
        rel_valid = 1'b0;
        #1;
        chk("reuse_grant", 64'(req_grant), 64'(4'b0001));
        chk("reuse_id", 64'(req_id), TRACK ? 64'(2) : 64'(1));
        @(posedge clk); #1;
        chk("reuse_sp_id", 64'(sp_packet_id), TRACK ? 64'(2) : 64'(1));
        chk("reuse_in_use", 64'(ids_in_use), TRACK ? 64'(32) : 64'(0));

        // release of a free ID, then reset while holding
        do_reset();
        rel_valid = 1'b1; rel_id = 5'd3;
        @(posedge clk); #1;
        chk("bad_rel_err", 64'(rel_err), 64'(TRACK));
        chk("bad_rel_in_use", 64'(ids_in_use), 64'(0));
        @(negedge clk);
        rel_valid = 1'b0; req_valid = 4'b0001; sp_ack = 1'b0;
        #1;
        chk("pre_rst_grant", 64'(req_grant), 64'(4'b0001));
        @(posedge clk); #1;
        chk("pre_rst_sp_valid", 64'(sp_valid), 64'(1));
        chk("pre_rst_in_use", 64'(ids_in_use), TRACK ? 64'(1) : 64'(0));
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        @(posedge clk); #1;
        chk("rst_hold_sp_valid", 64'(sp_valid), 64'(0));
        chk("rst_hold_in_use", 64'(ids_in_use), 64'(0));
        chk("rst_hold_rel_err", 64'(rel_err), 64'(0));
        chk("rst_hold_sp_id", 64'(sp_packet_id), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
